// File: rtl/operand_fetch.sv
// operand_fetch: decode / register-read stage of the Beta pipeline.
// This stage decodes the instruction and drives the register file read
// addresses. It resolves read-after-write hazards against the EX, MEM and WB
// stages, then loads the ID/EX pipeline register using a valid/ready handshake.
//
// Build option OPERAND_BYPASS_EN:
//   defined   - EX > MEM > WB > register-file forwarding; only load-use stalls.
//   undefined - no forwarding; stall while any used source has a pending
//               write in EX, MEM or WB; operands come from the register file.
module operand_fetch #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h83FFF800
) (
    input  logic            clk,
    input  logic            rst_n,
    // fetch side
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic            id_ready,
    input  logic            flush,
    // register file read ports
    output logic [4:0]      rf_ra1,
    output logic [4:0]      rf_ra2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    // EX stage state
    input  logic            ex_valid,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_wa,
    input  logic [XLEN-1:0] ex_result,
    // MEM stage state
    input  logic            mem_valid,
    input  logic            mem_we,
    input  logic [4:0]      mem_wa,
    input  logic [XLEN-1:0] mem_result,
    // write-back port (same strobe that writes the register file)
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    // ID/EX pipeline register
    output logic            de_valid,
    input  logic            de_ready,
    output logic [31:0]     de_instr,
    output logic [31:0]     de_pc,
    output logic [XLEN-1:0] de_a,
    output logic [XLEN-1:0] de_b,
    output logic [XLEN-1:0] de_lit,
    output logic [4:0]      de_rc
);

    localparam logic [5:0] OPC_ST  = 6'h19;
    localparam logic [5:0] OPC_LDR = 6'h1F;
    localparam logic [4:0] R_ZERO  = 5'd31;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0]      opc;
    logic [4:0]      rc_f;
    logic [4:0]      ra_f;
    logic [4:0]      rb_f;
    logic            uses_a;
    logic            uses_b;
    logic            is_st;
    logic [XLEN-1:0] lit_sx;

    assign opc    = if_instr[31:26];
    assign rc_f   = if_instr[25:21];
    assign ra_f   = if_instr[20:16];
    assign rb_f   = if_instr[15:11];
    assign is_st  = (opc == OPC_ST);
    // LDR addresses relative to the PC, so its ra field is not a source.
    assign uses_a = (opc != OPC_LDR);
    // Register-form ALU ops read rb; ST reads rc as the store data.
    assign uses_b = (opc[5:4] == 2'b10) || is_st;
    assign lit_sx = {{(XLEN-16){if_instr[15]}}, if_instr[15:0]};

    // Read addresses go straight to the register file so data returns this cycle.
    assign rf_ra1 = ra_f;
    assign rf_ra2 = is_st ? rc_f : rb_f;

    // ------------------------------------------------------------------
    // Per-source hazard detection and operand selection
    // ------------------------------------------------------------------
    logic [1:0][4:0]      src;
    logic [1:0]           src_used;
    logic [1:0][XLEN-1:0] src_rd;
    logic [1:0][XLEN-1:0] opnd;
    logic [1:0]           src_haz;

    assign src[0]   = rf_ra1;
    assign src[1]   = rf_ra2;
    assign src_used = {uses_b, uses_a};
    assign src_rd   = {rf_rd2, rf_rd1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic            live;
            logic            ex_hit;
            logic            mem_hit;
            logic            wb_hit;
            logic [XLEN-1:0] val;

            // r31 is hard-wired zero, so it never takes part in a hazard.
            assign live    = (src[gi] != R_ZERO);
            assign ex_hit  = live & ex_valid  & ex_we  & (ex_wa  == src[gi]);
            assign mem_hit = live & mem_valid & mem_we & (mem_wa == src[gi]);
            assign wb_hit  = live & wb_we & (wb_wa == src[gi]);

`ifdef OPERAND_BYPASS_EN
            // Load data only appears in MEM, so only a load still in EX must wait.
            assign src_haz[gi] = src_used[gi] & ex_hit & ex_is_load;

            // Youngest producer wins; the WB path covers the write that lands at this edge.
            always_comb begin
                val = src_rd[gi];
                if (!live)
                    val = '0;
                else if (ex_hit)
                    val = ex_result;
                else if (mem_hit)
                    val = mem_result;
                else if (wb_hit)
                    val = wb_wd;
            end
`else
            // Without forwarding, wait until every older write has reached the file.
            assign src_haz[gi] = src_used[gi] & (ex_hit | mem_hit | wb_hit);
            assign val         = live ? src_rd[gi] : '0;
`endif
            assign opnd[gi] = val;
        end
    endgenerate

`ifndef OPERAND_BYPASS_EN
    // Forwarding data inputs have no consumer in this build.
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_is_load, ex_result, mem_result, wb_wd};
`endif

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic stall;
    logic xfer;

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     pc_q,    pc_d;
    logic [XLEN-1:0] a_q,     a_d;
    logic [XLEN-1:0] b_q,     b_d;
    logic [XLEN-1:0] lit_q,   lit_d;
    logic [4:0]      rc_q,    rc_d;

    assign stall    = if_valid & (|src_haz);
    assign id_ready = (~valid_q | de_ready) & ~stall & ~flush;
    assign xfer     = if_valid & id_ready;

    // Next state of the ID/EX register: flush, then transfer, then drain/bubble, else hold.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        lit_d   = lit_q;
        rc_d    = rc_q;
        if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end else if (xfer) begin
            valid_d = 1'b1;
            instr_d = if_instr;
            pc_d    = if_pc;
            a_d     = opnd[0];
            b_d     = opnd[1];
            lit_d   = lit_sx;
            rc_d    = rc_f;
        end else if (de_ready | ~valid_q) begin
            // Register is free but nothing new arrived; a stall inserts a bubble.
            valid_d = 1'b0;
            if (stall)
                instr_d = NOP_INSTR;
        end
    end

    // ID/EX pipeline register with asynchronous reset to an empty bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            lit_q   <= '0;
            rc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lit_q   <= lit_d;
            rc_q    <= rc_d;
        end
    end

    assign de_valid = valid_q;
    assign de_instr = instr_q;
    assign de_pc    = pc_q;
    assign de_a     = a_q;
    assign de_b     = b_q;
    assign de_lit   = lit_q;
    assign de_rc    = rc_q;

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed test of the operand_fetch stage.
// It includes a small register-file model that is written by the WB port.
// Expected values track the OPERAND_BYPASS_EN build option.
module tb_operand_fetch;

    localparam logic [31:0] NOP     = 32'h83FFF800;
    localparam logic [5:0]  OP_ADD  = 6'h20;
    localparam logic [5:0]  OP_SUB  = 6'h21;
    localparam logic [5:0]  OP_ST   = 6'h19;
    localparam logic [5:0]  OP_LDR  = 6'h1F;
    localparam logic [5:0]  OP_ADDC = 6'h30;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        flush;
    logic [4:0]  rf_ra1;
    logic [4:0]  rf_ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic        ex_valid, ex_we, ex_is_load;
    logic [4:0]  ex_wa;
    logic [31:0] ex_result;
    logic        mem_valid, mem_we;
    logic [4:0]  mem_wa;
    logic [31:0] mem_result;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic        de_valid;
    logic        de_ready;
    logic [31:0] de_instr;
    logic [31:0] de_pc;
    logic [31:0] de_a;
    logic [31:0] de_b;
    logic [31:0] de_lit;
    logic [4:0]  de_rc;

    logic [31:0] rf [32];
    int          n_cmp;
    int          n_bad;
    logic [31:0] held_instr;

    assign rf_rd1 = rf[rf_ra1];
    assign rf_rd2 = rf[rf_ra2];

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .flush      (flush),
        .rf_ra1     (rf_ra1),
        .rf_ra2     (rf_ra2),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .ex_valid   (ex_valid),
        .ex_we      (ex_we),
        .ex_is_load (ex_is_load),
        .ex_wa      (ex_wa),
        .ex_result  (ex_result),
        .mem_valid  (mem_valid),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_result (mem_result),
        .wb_we      (wb_we),
        .wb_wa      (wb_wa),
        .wb_wd      (wb_wd),
        .de_valid   (de_valid),
        .de_ready   (de_ready),
        .de_instr   (de_instr),
        .de_pc      (de_pc),
        .de_a       (de_a),
        .de_b       (de_b),
        .de_lit     (de_lit),
        .de_rc      (de_rc)
    );

    function automatic logic [31:0] op_r(input logic [5:0] opc, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [4:0] rb);
        return {opc, rc, ra, rb, 11'd0};
    endfunction

    function automatic logic [31:0] op_l(input logic [5:0] opc, input logic [4:0] rc,
                                         input logic [4:0] ra, input logic [15:0] lit);
        return {opc, rc, ra, lit};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok   %s = %h", tag, got);
        end
    endtask

    // One clock; the register-file model takes the WB write just after the edge.
    task automatic tick();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = wb_we;
        a = wb_wa;
        d = wb_wd;
        @(posedge clk);
        #1;
        if (w) rf[a] = d;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
    endtask

    task automatic clear_stages();
        ex_valid = 1'b0; ex_we = 1'b0; ex_is_load = 1'b0; ex_wa = 5'd0; ex_result = 32'd0;
        mem_valid = 1'b0; mem_we = 1'b0; mem_wa = 5'd0; mem_result = 32'd0;
        wb_we = 1'b0; wb_wa = 5'd0; wb_wd = 32'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        if_valid = 1'b0; if_instr = NOP; if_pc = 32'd0;
        flush = 1'b0; de_ready = 1'b1;
        clear_stages();
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + 32'(i);
        rf[31] = 32'hDEAD0031;
        rf[2]  = 32'd5;
        rf[3]  = 32'd7;

        // ---- reset state
        tick(); tick();
        check_eq("rst_valid", 32'(de_valid), 32'd0);
        check_eq("rst_instr", de_instr, NOP);
        check_eq("rst_a", de_a, 32'd0);
        check_eq("rst_pc", de_pc, 32'd0);
        rst_n = 1'b1;

        // ---- 1: plain ADD r1,r2,r3
        issue(op_r(OP_ADD, 5'd1, 5'd2, 5'd3), 32'h104); #1;
        check_eq("t1_ra1", 32'(rf_ra1), 32'd2);
        check_eq("t1_ra2", 32'(rf_ra2), 32'd3);
        check_eq("t1_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t1_valid", 32'(de_valid), 32'd1);
        check_eq("t1_a", de_a, 32'd5);
        check_eq("t1_b", de_b, 32'd7);
        check_eq("t1_rc", 32'(de_rc), 32'd1);
        check_eq("t1_pc", de_pc, 32'h104);
        if_valid = 1'b0; #1;
        tick();
        check_eq("t1_drain", 32'(de_valid), 32'd0);

        // ---- 2: r2 written by EX, MEM and WB at once
        ex_valid = 1'b1; ex_we = 1'b1; ex_wa = 5'd2; ex_result = 32'h10;
        mem_valid = 1'b1; mem_we = 1'b1; mem_wa = 5'd2; mem_result = 32'h20;
        wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'h30;
        issue(op_r(OP_ADD, 5'd8, 5'd2, 5'd3), 32'h200); #1;
`ifdef OPERAND_BYPASS_EN
        check_eq("t2_ex_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t2_fwd_ex", de_a, 32'h10);
        ex_valid = 1'b0; #1;
        check_eq("t2_mem_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t2_fwd_mem", de_a, 32'h20);
        mem_valid = 1'b0; wb_wd = 32'h33; #1;
        check_eq("t2_wb_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t2_fwd_wb", de_a, 32'h33);
`else
        check_eq("t2_ex_rdy", 32'(id_ready), 32'd0);
        tick();
        check_eq("t2_bub_valid", 32'(de_valid), 32'd0);
        check_eq("t2_bub_instr", de_instr, NOP);
        ex_valid = 1'b0; #1;
        check_eq("t2_mem_rdy", 32'(id_ready), 32'd0);
        tick();
        mem_valid = 1'b0; wb_wd = 32'h33; #1;
        check_eq("t2_wb_rdy", 32'(id_ready), 32'd0);
        tick();
`endif
        wb_we = 1'b0; #1;
        check_eq("t2_rf_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t2_rf_a", de_a, 32'h33);
        check_eq("t2_rf_valid", 32'(de_valid), 32'd1);

        // ---- 3: load-use on r4
        clear_stages();
        rf[4] = 32'h44; rf[6] = 32'd6;
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd4; ex_result = 32'h400;
        issue(op_r(OP_SUB, 5'd5, 5'd4, 5'd6), 32'h300); #1;
        check_eq("t3_lu_rdy", 32'(id_ready), 32'd0);
        tick();
        check_eq("t3_bub_valid", 32'(de_valid), 32'd0);
        check_eq("t3_bub_instr", de_instr, NOP);
        ex_valid = 1'b0; ex_is_load = 1'b0;
        mem_valid = 1'b1; mem_we = 1'b1; mem_wa = 5'd4; mem_result = 32'h4D; #1;
`ifdef OPERAND_BYPASS_EN
        check_eq("t3_mem_rdy", 32'(id_ready), 32'd1);
        tick();
        mem_valid = 1'b0;
`else
        check_eq("t3_mem_rdy", 32'(id_ready), 32'd0);
        tick();
        mem_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd4; wb_wd = 32'h4D; #1;
        check_eq("t3_wb_rdy", 32'(id_ready), 32'd0);
        tick();
        wb_we = 1'b0; #1;
        check_eq("t3_rf_rdy", 32'(id_ready), 32'd1);
        tick();
`endif
        check_eq("t3_a", de_a, 32'h4D);
        check_eq("t3_b", de_b, 32'd6);
        check_eq("t3_rc", 32'(de_rc), 32'd5);

        // ---- 4: ST reads rc as operand B; r31 never forwards
        clear_stages();
        rf[1] = 32'h1000; rf[7] = 32'h77;
        ex_valid = 1'b1; ex_we = 1'b1; ex_wa = 5'd7; ex_result = 32'hAB;
        issue(op_l(OP_ST, 5'd7, 5'd1, 16'hFFFC), 32'h400); #1;
        check_eq("t4_ra2", 32'(rf_ra2), 32'd7);
`ifdef OPERAND_BYPASS_EN
        check_eq("t4_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t4_b", de_b, 32'hAB);
`else
        check_eq("t4_rdy", 32'(id_ready), 32'd0);
        tick();
        ex_valid = 1'b0; #1;
        check_eq("t4_rdy2", 32'(id_ready), 32'd1);
        tick();
        check_eq("t4_b", de_b, 32'h77);
`endif
        check_eq("t4_a", de_a, 32'h1000);
        check_eq("t4_lit", de_lit, 32'hFFFFFFFC);

        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd31; ex_result = 32'hFF;
        issue(op_r(OP_ADD, 5'd9, 5'd31, 5'd31), 32'h404); #1;
        check_eq("t4_r31_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t4_r31_a", de_a, 32'd0);
        check_eq("t4_r31_b", de_b, 32'd0);

        // unused source fields must not stall (EX load to r4 pending)
        ex_wa = 5'd4;
        issue(op_l(OP_LDR, 5'd10, 5'd4, 16'h0010), 32'h408); #1;
        check_eq("t4_ldr_rdy", 32'(id_ready), 32'd1);
        issue(op_l(OP_ADDC, 5'd10, 5'd3, 16'h2000), 32'h40C); #1;
        check_eq("t4_addc_rdy", 32'(id_ready), 32'd1);
        issue(op_r(OP_ADD, 5'd10, 5'd3, 5'd4), 32'h410); #1;
        check_eq("t4_rb_rdy", 32'(id_ready), 32'd0);
        tick();
        clear_stages();

        // ---- 5: backpressure hold, then flush
        if_valid = 1'b0; #1;
        tick();
        de_ready = 1'b0;
        held_instr = op_r(OP_ADD, 5'd1, 5'd2, 5'd3);
        issue(held_instr, 32'h500); #1;
        check_eq("t5_rdy0", 32'(id_ready), 32'd1);
        tick();
        check_eq("t5_valid0", 32'(de_valid), 32'd1);
        check_eq("t5_a0", de_a, 32'h33);
        issue(op_r(OP_SUB, 5'd5, 5'd2, 5'd3), 32'h504);
        rf[2] = 32'h99;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t5_hold_rdy", 32'(id_ready), 32'd0);
            tick();
            check_eq("t5_hold_valid", 32'(de_valid), 32'd1);
            check_eq("t5_hold_instr", de_instr, held_instr);
            check_eq("t5_hold_a", de_a, 32'h33);
            check_eq("t5_hold_pc", de_pc, 32'h500);
        end
        de_ready = 1'b1; flush = 1'b1; #1;
        check_eq("t5_flush_rdy", 32'(id_ready), 32'd0);
        tick();
        check_eq("t5_flush_valid", 32'(de_valid), 32'd0);
        check_eq("t5_flush_instr", de_instr, NOP);
        flush = 1'b0;

        // ---- 6: asynchronous reset in the middle of a load-use stall
        rf[4] = 32'h4E;
        ex_valid = 1'b1; ex_we = 1'b1; ex_is_load = 1'b1; ex_wa = 5'd4;
        issue(op_r(OP_SUB, 5'd5, 5'd4, 5'd6), 32'h600); #1;
        check_eq("t6_stall_rdy", 32'(id_ready), 32'd0);
        rst_n = 1'b0; #1;
        check_eq("t6_rst_valid", 32'(de_valid), 32'd0);
        check_eq("t6_rst_instr", de_instr, NOP);
        check_eq("t6_rst_a", de_a, 32'd0);
        clear_stages();
        tick();
        rst_n = 1'b1; #1;
        check_eq("t6_rdy", 32'(id_ready), 32'd1);
        tick();
        check_eq("t6_valid", 32'(de_valid), 32'd1);
        check_eq("t6_a", de_a, 32'h4E);
        check_eq("t6_pc", de_pc, 32'h600);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
